// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one external, purely combinational 4-bit ALU.
// One operation is in flight at a time and moves through IDLE -> EXEC -> RESP.
// In IDLE a single requester is granted combinationally. Its operands are
// captured on accept, presented to the ALU for one cycle in EXEC, and the ALU
// outputs are latched into the response registers at the end of EXEC. The
// response is then held in RESP until the granted requester consumes it.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int FIXED_PRIO = 0    // 0: round-robin on ties, 1: requester 0 wins ties
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active low

    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [5:0]  req_op,

    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [3:0]  rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_err,

    output logic        busy,

    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0] OP_UNDEF = 3'b111;

    // Select requester sel's 4-bit operand from a packed 2x4 bus.
    function automatic logic [3:0] pick_nibble(input logic [7:0] bus, input logic sel);
        logic [3:0] nib;
        if (sel) begin
            nib = bus[7:4];
        end else begin
            nib = bus[3:0];
        end
        return nib;
    endfunction

    // Select requester sel's 3-bit opcode from a packed 2x3 bus.
    function automatic logic [2:0] pick_op(input logic [5:0] bus, input logic sel);
        logic [2:0] opc;
        if (sel) begin
            opc = bus[5:3];
        end else begin
            opc = bus[2:0];
        end
        return opc;
    endfunction

    // One-hot requester mask for a requester id.
    function automatic logic [1:0] id_onehot(input logic id);
        logic [1:0] vec;
        if (id) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

    // State and registered outputs
    state_t      state_r;
    logic        grant_id_r;
    logic        last_grant_r;
    logic [3:0]  opa_r;         // operand registers; they also drive the ALU,
    logic [3:0]  opb_r;         // so they are non-zero only while in EXEC
    logic [2:0]  opc_r;
    logic [1:0]  rsp_valid_r;
    logic [3:0]  rsp_result_r;
    logic        rsp_carry_r;
    logic        rsp_zero_r;
    logic        rsp_err_r;
    logic        busy_r;

    // Combinational arbitration results
    logic [1:0]  grant_vec_s;
    logic        grant_id_s;
    logic        accept_s;
    logic        rsp_done_s;

    // Arbitration: in IDLE (and out of reset) pick one valid requester.
    always_comb begin
        grant_vec_s = 2'b00;
        grant_id_s  = 1'b0;
        if ((state_r == ST_IDLE) && reset) begin
            case (req_valid)
                2'b01: begin
                    grant_id_s  = 1'b0;
                    grant_vec_s = 2'b01;
                end
                2'b10: begin
                    grant_id_s  = 1'b1;
                    grant_vec_s = 2'b10;
                end
                2'b11: begin
                    if (FIXED_PRIO != 0) begin
                        grant_id_s = 1'b0;
                    end else begin
                        // hand the tie to whoever did not win last time
                        grant_id_s = ~last_grant_r;
                    end
                    grant_vec_s = id_onehot(grant_id_s);
                end
                default: begin
                    grant_id_s  = 1'b0;
                    grant_vec_s = 2'b00;
                end
            endcase
        end else begin
            grant_id_s  = 1'b0;
            grant_vec_s = 2'b00;
        end
    end

    // Handshake qualifiers: accept in IDLE, consume in RESP (granted bit only).
    always_comb begin
        accept_s   = |(req_valid & grant_vec_s);
        rsp_done_s = 1'b0;
        if (state_r == ST_RESP) begin
            rsp_done_s = grant_id_r ? rsp_ready[1] : rsp_ready[0];
        end else begin
            rsp_done_s = 1'b0;
        end
    end

    // Operation FSM with its registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;   // requester 0 wins the first tie
            opa_r        <= 4'd0;
            opb_r        <= 4'd0;
            opc_r        <= 3'd0;
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= 4'd0;
            rsp_carry_r  <= 1'b0;
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        opa_r        <= pick_nibble(req_a, grant_id_s);
                        opb_r        <= pick_nibble(req_b, grant_id_s);
                        opc_r        <= pick_op(req_op, grant_id_s);
                        grant_id_r   <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // ALU is combinational: its outputs settle within this cycle.
                    // The undefined opcode is flagged but its result passes through.
                    rsp_result_r <= alu_result;
                    rsp_carry_r  <= alu_carry;
                    rsp_zero_r   <= alu_zero;
                    rsp_err_r    <= (opc_r == OP_UNDEF);
                    rsp_valid_r  <= id_onehot(grant_id_r);
                    opa_r        <= 4'd0;
                    opb_r        <= 4'd0;
                    opc_r        <= 3'd0;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done_s) begin
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring: only req_ready is combinational, since grant must be same-cycle.
    always_comb begin
        req_ready  = grant_vec_s;
        rsp_valid  = rsp_valid_r;
        rsp_result = rsp_result_r;
        rsp_carry  = rsp_carry_r;
        rsp_zero   = rsp_zero_r;
        rsp_err    = rsp_err_r;
        busy       = busy_r;
        alu_a      = opa_r;
        alu_b      = opb_r;
        alu_op     = opc_r;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench: a transaction-level reference model plus a per-cycle
// comparator, and directed scenarios with hand-computed literal expectations.
// A second instance with FIXED_PRIO=1 shares the stimulus for the priority test.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_ready;

    // round-robin DUT
    logic [1:0]  req_ready, rsp_valid;
    logic [3:0]  rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_carry, rsp_zero, rsp_err, busy, alu_carry, alu_zero;
    logic [2:0]  alu_op;

    // fixed-priority DUT
    logic [1:0]  p_req_ready, p_rsp_valid;
    logic [3:0]  p_rsp_result, p_alu_a, p_alu_b, p_alu_result;
    logic        p_rsp_carry, p_rsp_zero, p_rsp_err, p_busy, p_alu_carry, p_alu_zero;
    logic [2:0]  p_alu_op;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // Bench ALU: returns {zero, carry, result[3:0]}. Op 111 behaves as ADD.
    function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [4:0] w;
        case (op)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} - {1'b0, b};
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            3'd5:    w = {1'b0, ~a};
            3'd6:    w = {a, 1'b0};
            3'd7:    w = {1'b0, a} + {1'b0, b};
            default: w = 5'd0;
        endcase
        return {(w[3:0] == 4'd0), w[4], w[3:0]};
    endfunction

    logic [5:0] alu0_s, alu1_s;
    assign alu0_s       = alu_model(alu_a, alu_b, alu_op);
    assign alu_result   = alu0_s[3:0];
    assign alu_carry    = alu0_s[4];
    assign alu_zero     = alu0_s[5];
    assign alu1_s       = alu_model(p_alu_a, p_alu_b, p_alu_op);
    assign p_alu_result = alu1_s[3:0];
    assign p_alu_carry  = alu1_s[4];
    assign p_alu_zero   = alu1_s[5];

    alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(p_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(p_rsp_result), .rsp_carry(p_rsp_carry), .rsp_zero(p_rsp_zero),
        .rsp_err(p_rsp_err), .busy(p_busy),
        .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_op(p_alu_op),
        .alu_result(p_alu_result), .alu_carry(p_alu_carry), .alu_zero(p_alu_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_phase: 0 = waiting for an operation, 1 = operation at the ALU,
    //          2 = answer offered to the requester
    int          m_phase = 0;
    logic        m_id = 1'b0;
    logic        m_last = 1'b1;
    logic [3:0]  m_a = 4'd0, m_b = 4'd0;
    logic [2:0]  m_op = 3'd0;
    logic [3:0]  m_res = 4'd0;
    logic        m_c = 1'b0, m_z = 1'b0, m_e = 1'b0;
    logic [1:0]  exp_rdy;

    // expected grant: lone requester wins; on a tie the one that did not go last
    always_comb begin
        exp_rdy = 2'b00;
        if (reset && (m_phase == 0)) begin
            if (req_valid == 2'b01) exp_rdy = 2'b01;
            else if (req_valid == 2'b10) exp_rdy = 2'b10;
            else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
            else exp_rdy = 2'b00;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_res   <= 4'd0;
            m_c     <= 1'b0;
            m_z     <= 1'b0;
            m_e     <= 1'b0;
        end else if (m_phase == 0) begin
            if (exp_rdy != 2'b00) begin
                m_id    <= exp_rdy[1];
                m_last  <= exp_rdy[1];
                m_a     <= exp_rdy[1] ? req_a[7:4]  : req_a[3:0];
                m_b     <= exp_rdy[1] ? req_b[7:4]  : req_b[3:0];
                m_op    <= exp_rdy[1] ? req_op[5:3] : req_op[2:0];
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            {m_z, m_c, m_res} <= alu_model(m_a, m_b, m_op);
            m_e     <= (m_op == 3'b111);
            m_phase <= 2;
        end else begin
            if (rsp_ready[m_id]) m_phase <= 0;
        end
    end

    // per-cycle comparison of the round-robin DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
            chk("m_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
            chk("m_alu_a", {28'd0, alu_a}, (m_phase == 1) ? {28'd0, m_a} : 32'd0);
            chk("m_alu_b", {28'd0, alu_b}, (m_phase == 1) ? {28'd0, m_b} : 32'd0);
            chk("m_alu_op", {29'd0, alu_op}, (m_phase == 1) ? {29'd0, m_op} : 32'd0);
            chk("m_rsp_valid", {30'd0, rsp_valid},
                (m_phase == 2) ? (m_id ? 32'd2 : 32'd1) : 32'd0);
            chk("m_rsp_result", {28'd0, rsp_result}, {28'd0, m_res});
            chk("m_rsp_carry", {31'd0, rsp_carry}, {31'd0, m_c});
            chk("m_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_z});
            chk("m_rsp_err", {31'd0, rsp_err}, {31'd0, m_e});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        if (id) begin
            req_a[7:4]  = a;
            req_b[7:4]  = b;
            req_op[5:3] = op;
        end else begin
            req_a[3:0]  = a;
            req_b[3:0]  = b;
            req_op[2:0] = op;
        end
    endtask

    // Issue one operation and return at the negedge where its response is shown.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
        int n;
        set_req(id, a, b, op);
        req_valid = id ? 2'b10 : 2'b01;
        n = 0;
        @(negedge clk);
        while ((req_ready[id] !== 1'b1) && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        chk("op_grant_wait", {31'd0, (n < 10)}, 32'd1);
        tick();
        req_valid = 2'b00;
        n = 0;
        @(negedge clk);
        while ((rsp_valid[id] !== 1'b1) && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        chk("op_rsp_wait", {31'd0, (n < 10)}, 32'd1);
    endtask

    logic g0 [4];
    logic g1 [4];

    initial begin
        int n0, n1, cyc;
        reset     = 1'b0;
        req_valid = 2'b00;
        req_a     = 8'd0;
        req_b     = 8'd0;
        req_op    = 6'd0;
        rsp_ready = 2'b11;
        tick();
        tick();
        chk_en = 1'b1;

        // requests while reset is low must not be granted
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_fp_req_ready", {30'd0, p_req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
        tick();
        req_valid = 2'b00;
        reset     = 1'b1;

        // lone ADD 7+5 from requester 0
        set_req(1'b0, 4'd7, 4'd5, 3'd0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("add_ready_c0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("add_alu_a_c1", {28'd0, alu_a}, 32'd7);
        chk("add_alu_b_c1", {28'd0, alu_b}, 32'd5);
        chk("add_alu_op_c1", {29'd0, alu_op}, 32'd0);
        chk("add_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        chk("add_rsp_valid_c2", {30'd0, rsp_valid}, 32'd1);
        chk("add_result_c2", {28'd0, rsp_result}, 32'd12);
        chk("add_carry_c2", {31'd0, rsp_carry}, 32'd0);
        chk("add_zero_c2", {31'd0, rsp_zero}, 32'd0);
        tick();
        @(negedge clk);
        chk("add_idle_c3", {31'd0, busy}, 32'd0);

        // both requesters continuously valid from reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(1'b0, 4'd3, 4'd4, 3'd0);
        set_req(1'b1, 4'd15, 4'd1, 3'd0);
        req_valid = 2'b11;
        n0 = 0;
        n1 = 0;
        cyc = 0;
        while (((n0 < 4) || (n1 < 4)) && (cyc < 30)) begin
            @(negedge clk);
            if ((req_ready != 2'b00) && (n0 < 4)) begin
                g0[n0] = req_ready[1];
                n0++;
            end
            if ((p_req_ready != 2'b00) && (n1 < 4)) begin
                g1[n1] = p_req_ready[1];
                n1++;
            end
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        chk("rr_grant_count", n0, 32'd4);
        chk("fp_grant_count", n1, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n0) chk("rr_grant_id", {31'd0, g0[i]}, i % 2);
            if (i < n1) chk("fp_grant_id", {31'd0, g1[i]}, 32'd0);
        end
        repeat (4) tick();

        // requester 1 ADD 9+9 with its response stalled; requester 0 waits
        set_req(1'b1, 4'd9, 4'd9, 3'd0);
        set_req(1'b0, 4'd6, 4'd6, 3'd1);
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        @(negedge clk);
        chk("stall_ready_c0", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        chk("stall_ready_exec", {30'd0, req_ready}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            chk("stall_result", {28'd0, rsp_result}, 32'd2);
            chk("stall_carry", {31'd0, rsp_carry}, 32'd1);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_no_grant", {30'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("stall_rsp_held", {30'd0, rsp_valid}, 32'd2);
        tick();
        @(negedge clk);
        chk("after_stall_grant0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("sub_result", {28'd0, rsp_result}, 32'd0);
        chk("sub_zero", {31'd0, rsp_zero}, 32'd1);
        chk("sub_carry", {31'd0, rsp_carry}, 32'd0);
        tick();

        // undefined opcode flagged, result passes through; then a defined op
        run_op(1'b0, 4'd3, 4'd2, 3'b111);
        chk("undef_err", {31'd0, rsp_err}, 32'd1);
        chk("undef_result", {28'd0, rsp_result}, 32'd5);
        tick();
        run_op(1'b1, 4'd12, 4'd10, 3'b010);
        chk("and_err", {31'd0, rsp_err}, 32'd0);
        chk("and_result", {28'd0, rsp_result}, 32'd8);
        tick();
        run_op(1'b0, 4'd8, 4'd8, 3'b111);
        chk("undef2_err", {31'd0, rsp_err}, 32'd1);
        chk("undef2_result", {28'd0, rsp_result}, 32'd0);
        chk("undef2_carry", {31'd0, rsp_carry}, 32'd1);
        chk("undef2_zero", {31'd0, rsp_zero}, 32'd1);
        tick();

        // reset during EXEC aborts the operation without a response
        set_req(1'b0, 4'd1, 4'd1, 3'd0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("abort_accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        reset     = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", {31'd0, busy}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("abort_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop in case a wait is ever missed
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
